// File: rtl/simple_bus_pkg.sv
// Shared types and default widths for the simple_bus slave controller.
//   mode_e  : command opcode carried on the mode lines
//   state_e : controller FSM states
package simple_bus_pkg;

    localparam int unsigned DEF_AW = 8;
    localparam int unsigned DEF_DW = 8;

    typedef enum logic [1:0] {
        MODE_READ  = 2'b00,
        MODE_WRITE = 2'b01,
        MODE_INC   = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        BUSY  = 2'b10
    } state_e;

endpackage

// File: rtl/simple_bus_regfile.sv
// Local storage for the slave: 2**AW x DW array, one synchronous write port
// and one asynchronous read port sharing a single address.
//   clk   : write clock
//   we    : write enable
//   addr  : read/write address
//   wdata : write data
//   rdata : combinational read data at addr
// Contents are intentionally not reset.
module simple_bus_regfile #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Asynchronous read port
    assign rdata = mem[addr];

endmodule

// File: rtl/simple_bus_slave_ctrl.sv
// Slave-side controller for simple_bus: grants the requesting master, accepts
// start/addr/mode/wdata commands, waits WAIT_STATES cycles, then performs a
// read / write / increment on the local register file and pulses rdy.
//   clk, rst_n : clock, asynchronous active-low reset
//   req / gnt  : bus request in, registered grant out
//   start      : command strobe (honoured only in GRANT)
//   addr, mode, wdata : command payload, sampled with start
//   rdata, rdy : result data and one-cycle completion pulse
//   busy       : high while a command is in flight
//   err        : (only with SIMPLE_BUS_SLAVE_ERR_EN) error pulse alongside rdy
//                for reserved opcode or addresses in the reserved top page
module simple_bus_slave_ctrl
    import simple_bus_pkg::*;
#(
    parameter int unsigned AW          = DEF_AW,
    parameter int unsigned DW          = DEF_DW,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    output logic          gnt,
    input  logic          start,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rdy,
`ifdef SIMPLE_BUS_SLAVE_ERR_EN
    output logic          err,
`endif
    output logic          busy
);

    localparam int unsigned CW = 4;
`ifdef SIMPLE_BUS_SLAVE_ERR_EN
    localparam int unsigned DEPTH_LIMIT = (1 << AW) - 16;
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    mode_e         mode_q, mode_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          gnt_q, gnt_d;
    logic          rdy_q, rdy_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic          we_c;
    logic [DW-1:0] wr_data_c;
    logic [DW-1:0] rd_data_c;

    simple_bus_regfile #(
        .AW (AW),
        .DW (DW)
    ) u_regfile (
        .clk   (clk),
        .we    (we_c),
        .addr  (addr_q),
        .wdata (wr_data_c),
        .rdata (rd_data_c)
    );

    // State, latched command and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            mode_q  <= MODE_READ;
            wdata_q <= '0;
            gnt_q   <= 1'b0;
            rdy_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            rdy_q   <= rdy_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Next-state, command execution and output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        mode_d    = mode_q;
        wdata_d   = wdata_q;
        gnt_d     = gnt_q;
        rdy_d     = 1'b0;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        we_c      = 1'b0;
        wr_data_c = wdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = GRANT;
                    gnt_d   = 1'b1;
                end
            end
            GRANT: begin
                if (!req) begin
                    state_d = IDLE;
                    gnt_d   = 1'b0;
                end else if (start) begin
                    addr_d  = addr;
                    mode_d  = mode_e'(mode);
                    wdata_d = wdata;
                    cnt_d   = CW'(WAIT_STATES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    rdy_d = 1'b1;
                    case (mode_q)
                        MODE_READ: begin
                            rdata_d = rd_data_c;
                        end
                        MODE_WRITE: begin
                            we_c      = 1'b1;
                            wr_data_c = wdata_q;
                            rdata_d   = wdata_q;
                        end
                        MODE_INC: begin
                            // Natural DW-bit wrap: all-ones increments to zero
                            we_c      = 1'b1;
                            wr_data_c = rd_data_c + DW'(1);
                            rdata_d   = rd_data_c;
                        end
                        default: begin
                            rdata_d = '0;
`ifdef SIMPLE_BUS_SLAVE_ERR_EN
                            err_d   = 1'b1;
`endif
                        end
                    endcase
`ifdef SIMPLE_BUS_SLAVE_ERR_EN
                    // Reserved top page: no storage access, return zero
                    if (addr_q >= AW'(DEPTH_LIMIT)) begin
                        we_c    = 1'b0;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
`endif
                    if (req) begin
                        state_d = GRANT;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 1'b0;
            end
        endcase

        busy_d = (state_d == BUSY);
    end

    assign gnt   = gnt_q;
    assign rdy   = rdy_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;
`ifdef SIMPLE_BUS_SLAVE_ERR_EN
    assign err   = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule
